// File: rtl/spi_dac_master_mc.sv
// Multi-channel SPI (mode 0) master feeding NUM_CH serial DACs in parallel.
// One shared SCK / active-low CS, one MOSI per lane, MSB first.
// Frame sequence: IDLE -> SHIFT -> HOLD -> GAP -> IDLE.
// Optional feature macro: SPI_DAC_OFFSET_BIN_EN (invert each lane's MSB at latch
// time, turning a two's-complement sample into an offset-binary DAC code).
module spi_dac_master_mc #(
    parameter int NUM_CH  = 2,
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 2,
    parameter int CS_IDLE = 2
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic [NUM_CH*DATA_W-1:0] i_data,
    input  logic                     i_valid,
    output logic                     o_ready,
    output logic                     o_sck,
    output logic                     o_cs,
    output logic [NUM_CH-1:0]        o_mosi,
    output logic                     o_busy,
    output logic                     o_frame_done
);

    localparam int VEC_W   = NUM_CH * DATA_W;
    localparam int DIV_MAX = (CLK_DIV > CS_IDLE) ? CLK_DIV : CS_IDLE;
    localparam int BIT_W   = $clog2(DATA_W + 1);
    localparam int DIV_W   = $clog2(DIV_MAX + 1);

    localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] GAP_LAST  = DIV_W'(CS_IDLE - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // Word conversion applied once, when the lanes are captured.
    function automatic logic [VEC_W-1:0] latch_words(input logic [VEC_W-1:0] data);
        logic [VEC_W-1:0] w;
        w = data;
`ifdef SPI_DAC_OFFSET_BIN_EN
        for (int n = 0; n < NUM_CH; n++) begin
            w[n*DATA_W + DATA_W - 1] = ~data[n*DATA_W + DATA_W - 1];
        end
`endif
        return w;
    endfunction

    // Collect bit 'pos' of every lane into one MOSI vector.
    function automatic logic [NUM_CH-1:0] lane_bits(input logic [VEC_W-1:0] v, input int pos);
        logic [NUM_CH-1:0] b;
        b = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            b[n] = v[n*DATA_W + pos];
        end
        return b;
    endfunction

    // Shift each lane left by one independently so no bit leaks between lanes.
    function automatic logic [VEC_W-1:0] shift_lanes(input logic [VEC_W-1:0] v);
        logic [VEC_W-1:0] s;
        s = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            s[n*DATA_W +: DATA_W] = {v[n*DATA_W +: DATA_W-1], 1'b0};
        end
        return s;
    endfunction

    state_t              r_state, w_state;
    logic [BIT_W-1:0]    r_bit_cnt, w_bit_cnt;
    logic [DIV_W-1:0]    r_div_cnt, w_div_cnt;
    logic [VEC_W-1:0]    r_shift, w_shift;
    logic                r_sck, w_sck;
    logic                r_cs, w_cs;
    logic [NUM_CH-1:0]   r_mosi, w_mosi;
    logic                r_ready, w_ready;
    logic                r_frame_done, w_frame_done;
    logic                r_busy;
    logic [VEC_W-1:0]    w_latched;

    assign w_latched = latch_words(i_data);

    // Next-state and next-output decode; outputs are computed one cycle ahead
    // so that every port comes straight from a flop.
    always_comb begin
        w_state      = r_state;
        w_bit_cnt    = r_bit_cnt;
        w_div_cnt    = r_div_cnt;
        w_shift      = r_shift;
        w_sck        = r_sck;
        w_cs         = r_cs;
        w_mosi       = r_mosi;
        w_ready      = r_ready;
        w_frame_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                w_cs    = 1'b1;
                w_sck   = 1'b0;
                w_mosi  = '0;
                if (i_valid) begin
                    w_state   = ST_SHIFT;
                    w_shift   = w_latched;
                    w_mosi    = lane_bits(w_latched, DATA_W - 1);
                    w_cs      = 1'b0;
                    w_ready   = 1'b0;
                    w_bit_cnt = '0;
                    w_div_cnt = '0;
                end else begin
                    w_state = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                w_cs = 1'b0;
                if (r_div_cnt == HALF_LAST) begin
                    w_div_cnt = '0;
                    if (!r_sck) begin
                        w_sck = 1'b1;
                    end else begin
                        w_sck = 1'b0;
                        if (r_bit_cnt == BIT_LAST) begin
                            // Last bit stays on MOSI through HOLD.
                            w_state   = ST_HOLD;
                            w_bit_cnt = '0;
                        end else begin
                            w_bit_cnt = r_bit_cnt + BIT_W'(1);
                            w_shift   = shift_lanes(r_shift);
                            w_mosi    = lane_bits(r_shift, DATA_W - 2);
                        end
                    end
                end else begin
                    w_div_cnt = r_div_cnt + DIV_W'(1);
                end
            end
            ST_HOLD: begin
                w_cs  = 1'b0;
                w_sck = 1'b0;
                if (r_div_cnt == HALF_LAST) begin
                    w_state      = ST_GAP;
                    w_div_cnt    = '0;
                    w_cs         = 1'b1;
                    w_mosi       = '0;
                    w_frame_done = 1'b1;
                end else begin
                    w_div_cnt = r_div_cnt + DIV_W'(1);
                end
            end
            ST_GAP: begin
                w_cs    = 1'b1;
                w_sck   = 1'b0;
                w_mosi  = '0;
                w_ready = 1'b0;
                if (r_div_cnt == GAP_LAST) begin
                    w_state   = ST_IDLE;
                    w_div_cnt = '0;
                    w_ready   = 1'b1;
                end else begin
                    w_div_cnt = r_div_cnt + DIV_W'(1);
                end
            end
            default: begin
                w_state   = ST_IDLE;
                w_bit_cnt = '0;
                w_div_cnt = '0;
                w_shift   = '0;
                w_sck     = 1'b0;
                w_cs      = 1'b1;
                w_mosi    = '0;
                w_ready   = 1'b1;
            end
        endcase
    end

    // State, counters, shift registers and output flops; reset aborts any frame.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= '0;
            r_div_cnt    <= '0;
            r_shift      <= '0;
            r_sck        <= 1'b0;
            r_cs         <= 1'b1;
            r_mosi       <= '0;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_bit_cnt    <= w_bit_cnt;
            r_div_cnt    <= w_div_cnt;
            r_shift      <= w_shift;
            r_sck        <= w_sck;
            r_cs         <= w_cs;
            r_mosi       <= w_mosi;
            r_ready      <= w_ready;
            r_busy       <= ~w_ready;
            r_frame_done <= w_frame_done;
        end
    end

    assign o_ready      = r_ready;
    assign o_busy       = r_busy;
    assign o_sck        = r_sck;
    assign o_cs         = r_cs;
    assign o_mosi       = r_mosi;
    assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_spi_dac_master_mc.sv
// Directed bench for spi_dac_master_mc: a default-parameter instance and a
// NUM_CH=4 / DATA_W=12 / CLK_DIV=1 / CS_IDLE=3 instance sharing one clock.
module tb_spi_dac_master_mc;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [31:0] i_data = 32'h0;
    logic        i_valid = 1'b0;
    logic        o_ready, o_sck, o_cs, o_busy, o_frame_done;
    logic [1:0]  o_mosi;

    logic [47:0] d4_data = 48'h0;
    logic        d4_valid = 1'b0;
    logic        d4_ready, d4_sck, d4_cs, d4_busy, d4_frame_done;
    logic [3:0]  d4_mosi;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 sys_clk = ~sys_clk;

    spi_dac_master_mc u_dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .i_data(i_data), .i_valid(i_valid),
        .o_ready(o_ready), .o_sck(o_sck), .o_cs(o_cs), .o_mosi(o_mosi),
        .o_busy(o_busy), .o_frame_done(o_frame_done)
    );

    spi_dac_master_mc #(.NUM_CH(4), .DATA_W(12), .CLK_DIV(1), .CS_IDLE(3)) u_dut4 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .i_data(d4_data), .i_valid(d4_valid),
        .o_ready(d4_ready), .o_sck(d4_sck), .o_cs(d4_cs), .o_mosi(d4_mosi),
        .o_busy(d4_busy), .o_frame_done(d4_frame_done)
    );

    // Decoder for the default instance: captures MOSI on each SCK rise.
    logic        m_prev_sck = 1'b0, m_prev_cs = 1'b1;
    int          m_edges = 0, m_edges_cs_hi = 0, m_fd = 0;
    logic [15:0] m_cap0 = 16'h0, m_cap1 = 16'h0;
    always @(negedge sys_clk) begin
        if (m_prev_cs && !o_cs) begin
            m_edges = 0; m_cap0 = 16'h0; m_cap1 = 16'h0;
        end
        if (!m_prev_sck && o_sck) begin
            m_edges = m_edges + 1;
            m_cap0  = {m_cap0[14:0], o_mosi[0]};
            m_cap1  = {m_cap1[14:0], o_mosi[1]};
            if (o_cs) m_edges_cs_hi = m_edges_cs_hi + 1;
        end
        if (o_frame_done) m_fd = m_fd + 1;
        m_prev_sck = o_sck;
        m_prev_cs  = o_cs;
    end

    // Decoder for the four-lane instance.
    logic        n_prev_sck = 1'b0, n_prev_cs = 1'b1;
    int          n_edges = 0, n_edges_cs_hi = 0;
    logic [11:0] n_cap [4];
    always @(negedge sys_clk) begin
        if (n_prev_cs && !d4_cs) begin
            n_edges = 0;
            for (int k = 0; k < 4; k++) n_cap[k] = 12'h0;
        end
        if (!n_prev_sck && d4_sck) begin
            n_edges = n_edges + 1;
            for (int k = 0; k < 4; k++) n_cap[k] = {n_cap[k][10:0], d4_mosi[k]};
            if (d4_cs) n_edges_cs_hi = n_edges_cs_hi + 1;
        end
        n_prev_sck = d4_sck;
        n_prev_cs  = d4_cs;
    end

    // Expected DAC code for a word as the selected build transmits it.
    function automatic logic [15:0] cv16(input logic [15:0] w);
`ifdef SPI_DAC_OFFSET_BIN_EN
        return {~w[15], w[14:0]};
`else
        return w;
`endif
    endfunction

    function automatic logic [11:0] cv12(input logic [11:0] w);
`ifdef SPI_DAC_OFFSET_BIN_EN
        return {~w[11], w[10:0]};
`else
        return w;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next falling edge (decoders settled).
    task automatic tick();
        @(negedge sys_clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    logic [15:0] known0 [3];
    logic [15:0] known1 [3];
    int          fd_before;

    initial begin
        known0[0] = 16'h1357; known0[1] = 16'hBEEF; known0[2] = 16'h0F0F;
        known1[0] = 16'h2468; known1[1] = 16'hCAFE; known1[2] = 16'hF00D;

        // Reset state
        tick();
        chk("rst_cs", 32'(o_cs), 32'h1);
        chk("rst_sck", 32'(o_sck), 32'h0);
        chk("rst_mosi", 32'(o_mosi), 32'h0);
        chk("rst_ready", 32'(o_ready), 32'h1);
        chk("rst_busy", 32'(o_busy), 32'h0);
        chk("rst_fd", 32'(o_frame_done), 32'h0);
        tick();
        sys_rst_n = 1'b1;
        tick(); tick();

        // 1: single frame with default parameters
        i_data = {16'h5A3C, 16'hA5C3}; i_valid = 1'b1; cyc = 0;
        tick();
        i_valid = 1'b0;
        chk("t1_cs_c1", 32'(o_cs), 32'h0);
        chk("t1_ready_c1", 32'(o_ready), 32'h0);
        chk("t1_busy_c1", 32'(o_busy), 32'h1);
        chk("t1_mosi_c1", 32'(o_mosi), {30'h0, cv16(16'h5A3C)[15], cv16(16'hA5C3)[15]});
        run_to(66);
        chk("t1_cs_c66", 32'(o_cs), 32'h0);
        chk("t1_sck_c66", 32'(o_sck), 32'h0);
        run_to(67);
        chk("t1_cs_c67", 32'(o_cs), 32'h1);
        chk("t1_fd_c67", 32'(o_frame_done), 32'h1);
        chk("t1_mosi_c67", 32'(o_mosi), 32'h0);
        chk("t1_edges", 32'(m_edges), 32'd16);
        chk("t1_lane0", 32'(m_cap0), 32'(cv16(16'hA5C3)));
        chk("t1_lane1", 32'(m_cap1), 32'(cv16(16'h5A3C)));
        run_to(68);
        chk("t1_fd_c68", 32'(o_frame_done), 32'h0);
        chk("t1_ready_c68", 32'(o_ready), 32'h0);
        run_to(69);
        chk("t1_ready_c69", 32'(o_ready), 32'h1);
        chk("t1_busy_c69", 32'(o_busy), 32'h0);
        tick(); tick();

        // 2: valid held high, data changing every cycle
        fd_before = m_fd;
        i_valid = 1'b1;
        for (int c = 0; c < 207; c++) begin
            if (c % 69 == 0) begin
                chk("t2_ready_start", 32'(o_ready), 32'h1);
                i_data = {known1[c/69], known0[c/69]};
            end else begin
                i_data = {16'(c * 16'h0931), 16'(c * 16'h4B1D)};
            end
            if (c % 69 == 1) chk("t2_cs_low", 32'(o_cs), 32'h0);
            if (c % 69 == 67) begin
                chk("t2_lane0", 32'(m_cap0), 32'(cv16(known0[c/69])));
                chk("t2_lane1", 32'(m_cap1), 32'(cv16(known1[c/69])));
            end
            if (c % 69 == 68) chk("t2_ready_c68", 32'(o_ready), 32'h0);
            tick();
        end
        i_valid = 1'b0;
        tick(); tick();
        chk("t2_frames", 32'(m_fd - fd_before), 32'd3);
        chk("t2_idle_after", 32'(o_cs), 32'h1);

        // 3: reset mid-frame
        fd_before = m_fd;
        i_data = {16'h2222, 16'h1111}; i_valid = 1'b1; cyc = 0;
        tick();
        i_valid = 1'b0;
        run_to(30);
        sys_rst_n = 1'b0;
        #1;
        chk("t3_cs", 32'(o_cs), 32'h1);
        chk("t3_sck", 32'(o_sck), 32'h0);
        chk("t3_mosi", 32'(o_mosi), 32'h0);
        chk("t3_ready", 32'(o_ready), 32'h1);
        chk("t3_busy", 32'(o_busy), 32'h0);
        tick(); tick();
        sys_rst_n = 1'b1;
        repeat (80) tick();
        chk("t3_no_fd", 32'(m_fd - fd_before), 32'd0);
        chk("t3_idle_cs", 32'(o_cs), 32'h1);
        i_data = {16'hFEDC, 16'h1234}; i_valid = 1'b1; cyc = 0;
        tick();
        i_valid = 1'b0;
        run_to(67);
        chk("t3_edges", 32'(m_edges), 32'd16);
        chk("t3_lane0", 32'(m_cap0), 32'(cv16(16'h1234)));
        chk("t3_lane1", 32'(m_cap1), 32'(cv16(16'hFEDC)));
        chk("t3_fd", 32'(o_frame_done), 32'h1);
        run_to(70);

        // 5: valid pulses during an active frame are ignored
        fd_before = m_fd;
        i_data = {16'h0BAD, 16'hC0DE}; i_valid = 1'b1; cyc = 0;
        tick();
        i_valid = 1'b0;
        while (cyc < 67) begin
            i_valid = (cyc >= 10 && cyc <= 60) ? cyc[0] : 1'b0;
            tick();
        end
        i_valid = 1'b0;
        chk("t5_edges", 32'(m_edges), 32'd16);
        chk("t5_lane0", 32'(m_cap0), 32'(cv16(16'hC0DE)));
        chk("t5_lane1", 32'(m_cap1), 32'(cv16(16'h0BAD)));
        run_to(75);
        chk("t5_cs_idle", 32'(o_cs), 32'h1);
        chk("t5_ready", 32'(o_ready), 32'h1);
        chk("t5_edges_after", 32'(m_edges), 32'd16);
        chk("t5_frames", 32'(m_fd - fd_before), 32'd1);

        // 6: offset-binary boundary words
        i_data = {16'h7FFF, 16'h8000}; i_valid = 1'b1; cyc = 0;
        tick();
        i_valid = 1'b0;
        run_to(67);
`ifdef SPI_DAC_OFFSET_BIN_EN
        chk("t6_lane0", 32'(m_cap0), 32'h0000);
        chk("t6_lane1", 32'(m_cap1), 32'hFFFF);
`else
        chk("t6_lane0", 32'(m_cap0), 32'h8000);
        chk("t6_lane1", 32'(m_cap1), 32'h7FFF);
`endif
        run_to(70);

        // 4: four lanes, 12 bits, CLK_DIV=1, CS_IDLE=3 (period 29)
        chk("t4_ready_idle", 32'(d4_ready), 32'h1);
        d4_data = {12'h001, 12'h800, 12'h000, 12'hFFF}; d4_valid = 1'b1; cyc = 0;
        tick();
        d4_valid = 1'b0;
        chk("t4_cs_c1", 32'(d4_cs), 32'h0);
        chk("t4_sck_c1", 32'(d4_sck), 32'h0);
        run_to(2);
        chk("t4_sck_c2", 32'(d4_sck), 32'h1);
        run_to(3);
        chk("t4_sck_c3", 32'(d4_sck), 32'h0);
        run_to(25);
        chk("t4_cs_c25", 32'(d4_cs), 32'h0);
        run_to(26);
        chk("t4_fd_c26", 32'(d4_frame_done), 32'h1);
        chk("t4_edges", 32'(n_edges), 32'd12);
        chk("t4_lane0", 32'(n_cap[0]), 32'(cv12(12'hFFF)));
        chk("t4_lane1", 32'(n_cap[1]), 32'(cv12(12'h000)));
        chk("t4_lane2", 32'(n_cap[2]), 32'(cv12(12'h800)));
        chk("t4_lane3", 32'(n_cap[3]), 32'(cv12(12'h001)));
        run_to(28);
        chk("t4_ready_c28", 32'(d4_ready), 32'h0);
        run_to(29);
        chk("t4_ready_c29", 32'(d4_ready), 32'h1);

        // SCK never rises with CS deasserted
        chk("sck_cs_hi", 32'(m_edges_cs_hi), 32'd0);
        chk("sck_cs_hi4", 32'(n_edges_cs_hi), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_dac_master_mc.md
Name: spi_dac_master_mc

Overview:
Parametrised multi-channel SPI master that drives serial DACs from the filter outputs. It shares one SCK/CS across NUM_CH DACs and drives one MOSI line per channel in parallel. It replaces the fixed two-lane, 16-bit spi_master. Additions over spi_master: a valid/ready input handshake, a programmable SCK divider, a programmable CS inter-frame gap, and a frame-done strobe.

Parameters:
NUM_CH, 2, number of parallel DAC data lanes (>=1)
DATA_W, 16, bits per frame per lane (>=2)
CLK_DIV, 2, sys_clk cycles per SCK half-period (>=1)
CS_IDLE, 2, sys_clk cycles CS held high between frames (>=1)

Ports:
sys_clk  in  1  single clock for all logic
sys_rst_n  in  1  reset, asynchronous assert, active-low
i_data  in  NUM_CH*DATA_W  lane n word at [n*DATA_W +: DATA_W]
i_valid  in  1  i_data valid
o_ready  out  1  block idle, can accept a word
o_sck  out  1  SPI clock, idle low
o_cs  out  1  active-low chip select, common to all lanes
o_mosi  out  NUM_CH  serial data, one bit per lane, MSB first
o_busy  out  1  frame in progress (inverse of o_ready)
o_frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (async, sys_rst_n=0): state IDLE, o_cs=1, o_sck=0, o_mosi=0, o_ready=1, o_busy=0, o_frame_done=0, shift regs cleared. All outputs are registered.
- Reset asserted mid-frame: frame aborts immediately, outputs go to reset values, no frame_done pulse.
- SPI mode 0. MOSI changes only while SCK is low; the DAC samples on the SCK rising edge.
- FSM: IDLE -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE: o_ready=1. On i_valid & o_ready in cycle 0:
  - latch all lanes into per-lane shift registers (i_data is sampled only here);
  - enter SHIFT.
- SHIFT, from cycle 1:
  - o_cs=0, o_mosi[n]=lane n MSB.
  - Each bit lasts 2*CLK_DIV cycles: SCK low for the first CLK_DIV, high for the second CLK_DIV.
  - At the end of each bit, the shift registers shift left and MOSI presents the next bit.
  - After DATA_W bits, enter HOLD with SCK low.
- HOLD: CLK_DIV cycles, o_cs=0, o_sck=0, MOSI holds the last bit.
- GAP: CS_IDLE cycles, o_cs=1, o_mosi=0, o_ready=0. o_frame_done=1 in the first GAP cycle only.
- Return to IDLE: o_ready=1.
- Handshake-to-next-ready period = 1 + 2*CLK_DIV*DATA_W + CLK_DIV + CS_IDLE cycles. With defaults this is 69: ready is low for cycles 1..68 and high again at cycle 69.
- i_valid while o_ready=0 is ignored; no queuing.
- i_valid held high produces back-to-back frames, one per period.
- Counters:
  - bit counter width clog2(DATA_W+1);
  - divider counter width clog2(max(CLK_DIV, CS_IDLE)+1).
  - Both wrap to 0 on every state change.
- Exactly DATA_W rising SCK edges per frame, all while CS is low.

Optional Feature:
SPI_DAC_OFFSET_BIN_EN.
- Defined: each lane's MSB is inverted at latch time, converting two's-complement filter output to offset-binary DAC code. 0x8000 is sent as 0x0000; 0x0000 is sent as 0x8000.
- Undefined: words are shifted out unmodified.

Test Plan:
1. Defaults, lane0=0xA5C3, lane1=0x5A3C, one valid pulse.
   - CS low for cycles 1..66; 16 SCK rising edges.
   - Bits captured on rising SCK give 0xA5C3 / 0x5A3C.
   - frame_done at cycle 67; ready returns at cycle 69.
2. i_valid held high, data changing every cycle -> frames start at cycles 0, 69 and 138; each frame sends the word present at its handshake cycle only.
3. Reset asserted at cycle 30 of a frame -> same cycle: CS=1, SCK=0, MOSI=0, ready=1; no frame_done; next valid starts a clean frame.
4. NUM_CH=4, DATA_W=12, CLK_DIV=1, CS_IDLE=3, data 0xFFF/0x000/0x800/0x001.
   - Period 1+24+1+3=29.
   - SCK period 2 cycles; all four lanes decoded correctly.
5. Pulse i_valid during cycles 10..60 of an active frame -> ignored: no extra frame, 16 SCK edges only.
6. SPI_DAC_OFFSET_BIN_EN defined, lane0=0x8000, lane1=0x7FFF -> decoded 0x0000 / 0xFFFF. Undefined, same inputs -> decoded 0x8000 / 0x7FFF.
